// File: rtl/imem_loader.sv
// Byte-stream loader that writes a program into CPU instruction memory and then releases CPU reset.
// Optional trailing XOR checksum byte enabled by `define LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] CHK   = 3'd4;
  localparam logic [2:0] RUN   = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] n_rx;

  assign accept = in_valid & in_ready;
  assign n_rx   = {len_hi_q, in_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (accept && (state_q == LEN || state_q == DATA)) begin
      csum_d = csum_q ^ in_data;
    end
`endif

    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d    = LEN;
          byte_cnt_d = '0;
          word_idx_d = '0;
          shift_d    = '0;
          addr_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            len_hi_d   = in_data;
            byte_cnt_d = 2'd1;
          end else begin
            n_d        = n_rx;
            byte_cnt_d = '0;
            if ({1'b0, n_rx} > MAX_N) begin
              state_d = ERR;
            end else if (n_rx == 16'd0) begin
              state_d = FLUSH;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Only complete words reach the output register; partial bytes stay in shift_q.
          if (byte_cnt_q == 2'd3) begin
            data_d     = {shift_q, in_data};
            addr_d     = {14'b0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == 16'(n_q - 16'd1)) begin
              state_d = FLUSH;
            end
          end else begin
            shift_d = {shift_q[15:0], in_data};
          end
        end
      end
      FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = CHK;
`else
        state_d = RUN;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? RUN : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      len_hi_q   <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      addr_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready   = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign busy       = (state_q == LEN) || (state_q == DATA) || (state_q == FLUSH) || (state_q == CHK);
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERR);
  assign initialize = (state_q != RUN);
  assign cpu_rst    = (state_q != RUN);

  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader; expectations come from a byte-level program model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        initialize;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.MAX_WORDS(256)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .in_valid                       (in_valid),
    .in_data                        (in_data),
    .in_ready                       (in_ready),
    .initialize                     (initialize),
    .instruction_initialize_data    (idata),
    .instruction_initialize_address (iaddr),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done),
    .error                          (error)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len_busy", {31'b0, busy}, 32'd1);
    check("len_ready", {31'b0, in_ready}, 32'd1);
    check("len_error", {31'b0, error}, 32'd0);
    check("len_addr", iaddr, 32'd0);
  endtask

  // Loads a whole program; wrong_csum only matters when the checksum byte is part of the stream.
  task automatic run_load(input logic [31:0] words[$], input int mode, input bit wrong_csum);
    int n;
    logic [7:0] csum;
    logic [7:0] bt;
    n = words.size();
    pulse_start();
    csum = 8'(n >> 8) ^ 8'(n);
    send_byte(8'(n >> 8), pick_gap(mode));
    send_byte(8'(n), pick_gap(mode));
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        bt = 8'(words[k] >> (24 - 8 * b));
        csum ^= bt;
        send_byte(bt, pick_gap(mode));
        if (b < 3) begin
          check("no_partial_word", idata, exp_data);
        end else begin
          exp_data = words[k];
          check("word_data", idata, exp_data);
          check("word_addr", iaddr, 32'(4 * k));
        end
      end
    end
    check("flush_busy", {31'b0, busy}, 32'd1);
    check("flush_init", {31'b0, initialize}, 32'd1);
    check("flush_ready", {31'b0, in_ready}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
`ifdef LOADER_CHECKSUM_EN
    check("chk_ready", {31'b0, in_ready}, 32'd1);
    send_byte(wrong_csum ? (csum ^ 8'h01) : csum, pick_gap(mode));
    if (wrong_csum) begin
      check("csum_err", {31'b0, error}, 32'd1);
      check("csum_err_cpu_rst", {31'b0, cpu_rst}, 32'd1);
      check("csum_err_done", {31'b0, done}, 32'd0);
      return;
    end
`else
    if (wrong_csum) return;
`endif
    check("run_done", {31'b0, done}, 32'd1);
    check("run_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("run_init", {31'b0, initialize}, 32'd0);
    check("run_busy", {31'b0, busy}, 32'd0);
    check("run_data", idata, exp_data);
    check("run_addr", iaddr, (n == 0) ? 32'd0 : 32'(4 * (n - 1)));
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] empty[$];
    int len;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    exp_data = '0;
    #12;
    check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("rst_init", {31'b0, initialize}, 32'd1);
    check("rst_data", idata, 32'd0);
    check("rst_addr", iaddr, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_flags", {29'b0, busy, done, error}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'b0, in_ready}, 32'd0);

    // Reference program, back-to-back and then with in_valid toggling.
    prog = '{32'h00020820, 32'h8C0C000C};
    run_load(prog, 0, 1'b0);
    run_load(prog, 1, 1'b0);

    // Empty program: no write, address reset, data unchanged.
    run_load(empty, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      prog.delete();
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) prog.push_back($urandom);
      run_load(prog, 2, 1'b0);
    end

    prog.delete();
    for (int k = 0; k < 256; k++) prog.push_back($urandom);
    run_load(prog, 0, 1'b0);

    // Oversize length goes to ERR; start from ERR re-enters LEN.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("err_flag", {31'b0, error}, 32'd1);
    check("err_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("err_busy", {31'b0, busy}, 32'd0);
    check("err_ready", {31'b0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("err_persist", {31'b0, error}, 32'd1);
    pulse_start();
    check("restart_error", {31'b0, error}, 32'd0);
    apply_reset();

    // start during DATA is ignored.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 0);
    check("ign_start_data", idata, 32'hDEADBEEF);
    check("ign_start_addr", iaddr, 32'd0);
    check("ign_start_busy", {31'b0, busy}, 32'd1);
    apply_reset();

    // Asynchronous reset in the middle of DATA.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 0);
    check("pre_rst_addr", iaddr, 32'd4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("async_init", {31'b0, initialize}, 32'd1);
    check("async_addr", iaddr, 32'd0);
    check("async_data", idata, 32'd0);
    check("async_busy", {31'b0, busy}, 32'd0);
    check("async_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    prog.delete();
    for (int k = 0; k < 3; k++) prog.push_back($urandom);
    run_load(prog, 2, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    prog = '{32'h00020820, 32'h8C0C000C};
    run_load(prog, 0, 1'b1);
    prog = '{32'h12345678};
    run_load(prog, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
